arbiter_rr_hs: RTL and testbench

//  Clocked N-way round-robin arbiter for one shared downstream req/ack channel.
//  - Every side uses a 4-phase handshake.
//  - Picks one requester, forwards its request, routes the downstream ack back
//    to it, then completes return-to-zero before the next grant.
//  - Scales the 2-requester selection arbiter to N requesters with fairness.
//  - Sits between a requester bank and one shared resource.

---
 rtl/arbiter_rr_hs.sv | 181 ++++++++++++++++++
 tb/tb_arbiter_rr_hs.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_hs.sv
// arbiter_rr_hs
//   Clocked N-way round-robin arbiter that shares one downstream 4-phase
//   req/ack channel among N 4-phase requesters. One requester is granted at a
//   time. Its request is forwarded downstream and the downstream ack is routed
//   back to it. The whole handshake returns to zero before the next grant.
//
// Ports
//   clk      in   1     rising-edge clock
//   rst_n    in   1     asynchronous active-low reset (released synchronously inside)
//   req_in   in   N     requests from the requester bank
//   ack_in   out  N     acknowledges to the requesters (one-hot or zero)
//   req_out  out  1     request to the shared downstream block
//   ack_out  in   1     acknowledge from the downstream block
//   sel      out  SELW  index of the granted requester, valid while busy=1
//   busy     out  1     high from grant until return-to-zero completes
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no grant; pick the round-robin winner among the synced requests
// S_FWD_REQ | req_out high for sel; wait for the downstream ack
// S_FWD_ACK | ack_in[sel] high; wait for requester sel to drop its request
// S_RTZ     | req_out low; wait for the downstream ack to drop, then release
module arbiter_rr_hs #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  localparam int SELW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_in,
  output logic [N-1:0]    ack_in,
  output logic            req_out,
  input  logic            ack_out,
  output logic [SELW-1:0] sel,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FWD_REQ = 2'd1,
    S_FWD_ACK = 2'd2,
    S_RTZ     = 2'd3
  } state_t;

  // Reset asserts asynchronously; its release is retimed to clk so every
  // flop below leaves reset on the same edge.
  logic [1:0] rst_q;
  logic       rst_i_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_i_n = rst_q[1];

  logic [N-1:0] req_s;
  logic         ack_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req_in;
      assign ack_s = ack_out;
    end else begin : g_sync
      logic [N-1:0]           req_q [SYNC_STAGES];
      logic [SYNC_STAGES-1:0] ack_q;

      always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) req_q[i] <= '0;
          ack_q <= '0;
        end else begin
          req_q[0] <= req_in;
          ack_q[0] <= ack_out;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            req_q[i] <= req_q[i-1];
            ack_q[i] <= ack_q[i-1];
          end
        end
      end

      assign req_s = req_q[SYNC_STAGES-1];
      assign ack_s = ack_q[SYNC_STAGES-1];
    end
  endgenerate

  state_t          state, state_nx;
  logic [SELW-1:0] ptr, ptr_nx;
  logic [SELW-1:0] sel_nx;
  logic            busy_nx;
  logic            req_out_nx;
  logic [N-1:0]    ack_in_nx;

  // Round-robin winner: first set request scanning from ptr upward, wrapping
  // back through 0. Only the first hit is kept.
  logic [SELW-1:0] winner;
  logic            found;
  int              idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_s[idx]) begin
        winner = SELW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      req_out <= 1'b0;
      ack_in  <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      sel     <= sel_nx;
      busy    <= busy_nx;
      req_out <= req_out_nx;
      ack_in  <= ack_in_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    sel_nx     = sel;
    busy_nx    = busy;
    req_out_nx = req_out;
    ack_in_nx  = ack_in;
    case (state)
      S_IDLE: begin
        if (found) begin
          sel_nx     = winner;
          busy_nx    = 1'b1;
          req_out_nx = 1'b1;
          state_nx   = S_FWD_REQ;
        end
      end
      S_FWD_REQ: begin
        // A requester that withdrew here still gets its ack pulse; the
        // downstream transaction cannot be cancelled once started.
        if (ack_s) begin
          ack_in_nx      = '0;
          ack_in_nx[sel] = 1'b1;
          state_nx       = S_FWD_ACK;
        end
      end
      S_FWD_ACK: begin
        if (!req_s[sel]) begin
          req_out_nx = 1'b0;
          state_nx   = S_RTZ;
        end
      end
      S_RTZ: begin
        if (!ack_s) begin
          ack_in_nx = '0;
          busy_nx   = 1'b0;
          ptr_nx    = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: begin
        state_nx   = S_IDLE;
        sel_nx     = '0;
        busy_nx    = 1'b0;
        req_out_nx = 1'b0;
        ack_in_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_arbiter_rr_hs.sv
module tb_arbiter_rr_hs;

  localparam int N    = 4;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_in = '0;
  logic [N-1:0] ack_in;
  logic         req_out;
  logic         ack_out = 1'b0;
  logic [1:0]   sel;
  logic         busy;

  int tot = 0;
  int bad = 0;
  bit auto_req = 0;
  bit auto_ack = 0;

  arbiter_rr_hs #(.N(N), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_in  (req_in),
    .ack_in  (ack_in),
    .req_out (req_out),
    .ack_out (ack_out),
    .sel     (sel),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: handshake phase counter driven by the delayed inputs.
  int           m_phase = 0;
  int           m_sel = 0;
  int           m_ptr = 0;
  logic         m_busy = 1'b0;
  logic         m_req_out = 1'b0;
  logic [N-1:0] m_ack_in = '0;
  logic [N-1:0] m_rh [SYNC] = '{default: '0};
  logic         m_ah [SYNC] = '{default: 1'b0};
  logic [N-1:0] m_rs;
  logic         m_as;
  bit           m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_sel = 0; m_ptr = 0;
      m_busy = 1'b0; m_req_out = 1'b0; m_ack_in = '0;
      for (int k = 0; k < SYNC; k++) begin
        m_rh[k] = '0;
        m_ah[k] = 1'b0;
      end
    end else begin
      m_rs = m_rh[SYNC-1];
      m_as = m_ah[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) begin
        m_rh[k] = m_rh[k-1];
        m_ah[k] = m_ah[k-1];
      end
      m_rh[0] = req_in;
      m_ah[0] = ack_out;
      if (m_phase == 0) begin
        if (m_rs != 0) begin
          m_hit = 0;
          for (int k = 0; k < N; k++) begin
            if (!m_hit && m_rs[(m_ptr + k) % N]) begin
              m_sel = (m_ptr + k) % N;
              m_hit = 1;
            end
          end
          m_busy = 1'b1; m_req_out = 1'b1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_as) begin
          m_ack_in = N'(1 << m_sel);
          m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (!m_rs[m_sel]) begin
          m_req_out = 1'b0;
          m_phase = 3;
        end
      end else begin
        if (!m_as) begin
          m_ack_in = '0; m_busy = 1'b0;
          m_ptr = (m_sel + 1) % N;
          m_phase = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tot++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // One clock step: compare against the model, then drive the random agents.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      chk("req_out", {31'b0, req_out}, {31'b0, m_req_out});
      chk("ack_in", {28'b0, ack_in}, {28'b0, m_ack_in});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      if (m_busy) chk("sel", {30'b0, sel}, m_sel);
    end
    if (auto_req) begin
      for (int i = 0; i < N; i++) begin
        if (!req_in[i] && !ack_in[i]) begin
          if ($urandom_range(0, 99) < 25) req_in[i] = 1'b1;
        end else if (req_in[i] && ack_in[i]) begin
          if ($urandom_range(0, 99) < 50) req_in[i] = 1'b0;
        end else if (req_in[i] && !ack_in[i]) begin
          if ($urandom_range(0, 999) < 5) req_in[i] = 1'b0;
        end
      end
    end
    if (auto_ack) begin
      if (ack_out != req_out && $urandom_range(0, 99) < 40) ack_out = req_out;
    end
  endtask

  // what: 0=req_out, 1=ack_in, 2=busy
  task automatic wait_for(input int what, input logic [N-1:0] val, input int budget,
                          output int cyc);
    logic [N-1:0] cur;
    bit hit;
    hit = 0;
    cyc = 0;
    cur = '0;
    while (!hit && cyc < budget) begin
      tick();
      cyc++;
      case (what)
        0:       cur = {3'b0, req_out};
        1:       cur = ack_in;
        default: cur = {3'b0, busy};
      endcase
      if (cur == val) hit = 1;
    end
    tot++;
    if (!hit) begin
      bad++;
      $display("FAIL wait%0d actual=%0h required=%0h after %0d cycles", what, cur, val, cyc);
    end
  endtask

  task automatic serve(input bit reraise, output int s);
    int c;
    wait_for(2, 4'b0001, 60, c);
    s = int'(sel);
    wait_for(1, N'(1 << s), 60, c);
    req_in[s] = 1'b0;
    wait_for(2, 4'b0000, 60, c);
    if (reraise) req_in[s] = 1'b1;
  endtask

  int c;
  int s;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_ack_in", {28'b0, ack_in}, 0);

    // single handshake
    req_in = 4'b0100;
    wait_for(0, 4'b0001, 20, c);
    chk("t2_req_lat", c, 3);
    chk("t2_sel", {30'b0, sel}, 2);
    chk("t2_busy", {31'b0, busy}, 1);
    ack_out = 1'b1;
    wait_for(1, 4'b0100, 20, c);
    chk("t2_ack_lat", c, 3);
    req_in = 4'b0000;
    wait_for(0, 4'b0000, 20, c);
    chk("t2_rtz_lat", c, 3);
    chk("t2_ack_held", {28'b0, ack_in}, 4'b0100);
    ack_out = 1'b0;
    wait_for(2, 4'b0000, 20, c);
    chk("t2_done_lat", c, 3);
    chk("t2_ack_clr", {28'b0, ack_in}, 0);
    tick();

    // wrap/skip from ptr=3
    auto_ack = 1;
    req_in = 4'b0011;
    serve(0, s);
    chk("t4_first", s, 0);
    serve(0, s);
    chk("t4_second", s, 1);
    repeat (3) tick();

    // late arrival while index 3 busy
    req_in = 4'b1000;
    wait_for(2, 4'b0001, 20, c);
    chk("t5_sel3", {30'b0, sel}, 3);
    req_in[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_hold_sel", {30'b0, sel}, 3);
      chk("t5_hold_req", {31'b0, req_out}, 1);
    end
    wait_for(1, 4'b1000, 60, c);
    req_in[3] = 1'b0;
    wait_for(2, 4'b0000, 60, c);
    serve(0, s);
    chk("t5_next", s, 1);
    repeat (3) tick();

    // withdrawal in FWD_REQ
    auto_ack = 0;
    req_in = 4'b0100;
    wait_for(0, 4'b0001, 20, c);
    req_in = 4'b0000;
    ack_out = 1'b1;
    wait_for(1, 4'b0100, 20, c);
    chk("t6_ack_only2", {28'b0, ack_in}, 4'b0100);
    wait_for(0, 4'b0000, 20, c);
    ack_out = 1'b0;
    wait_for(2, 4'b0000, 20, c);
    chk("t6_ack_clr", {28'b0, ack_in}, 0);
    tick();

    // reset mid-FWD_ACK, then fair order under full load
    req_in = 4'b0100;
    wait_for(0, 4'b0001, 20, c);
    ack_out = 1'b1;
    wait_for(1, 4'b0100, 20, c);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_req_out", {31'b0, req_out}, 0);
    chk("t1_ack_in", {28'b0, ack_in}, 0);
    chk("t1_busy", {31'b0, busy}, 0);
    chk("t1_sel", {30'b0, sel}, 0);
    req_in = 4'b0000;
    ack_out = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    auto_ack = 1;
    req_in = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      serve(1, s);
      chk("t3_order", s, exp_order[g]);
    end
    req_in = 4'b0000;
    repeat (20) tick();

    // randomized traffic against the model
    auto_req = 1;
    repeat (3000) tick();
    auto_req = 0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
